// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-ported, byte-lane data memory between the instruction
// fetch port (IF, word reads only) and the load/store port (LS, every RV32I
// load/store type). Only one access is in flight at a time. Each access
// moves through IDLE -> ISSUE -> (WAIT, reads only) -> RESP -> IDLE.
//
// Parameters
//   SIZE    memory byte-address width
//   RD_LAT  cycles from mem_en to valid mem_rdata (>= 1)
//
// Ports
//   clk, rst_n                    clock and synchronous active-low reset
//   if_req_valid/if_req_ready     IF request handshake
//   if_addr                       IF byte address; bits [1:0] are ignored
//   if_rsp_valid/if_rdata         one-cycle fetch response
//   ls_req_valid/ls_req_ready     LS request handshake
//   ls_addr, ls_ctrl, ls_wdata    LS address, access type, right-aligned store data
//   ls_rsp_valid/ls_rdata/ls_err  one-cycle LS response (load data, store ack or error)
//   mem_en/mem_we/mem_addr/mem_wdata  memory command, driven only in ISSUE
//   mem_rdata                     memory read data, valid RD_LAT cycles after mem_en
module dmem_arbiter #(
  parameter int SIZE   = 12,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [31:0]     if_addr,
  output logic            if_rsp_valid,
  output logic [31:0]     if_rdata,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [31:0]     ls_addr,
  input  logic [2:0]      ls_ctrl,
  input  logic [31:0]     ls_wdata,
  output logic            ls_rsp_valid,
  output logic [31:0]     ls_rdata,
  output logic            ls_err,
  output logic            mem_en,
  output logic [3:0]      mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [1:0]      state;
  logic            last_ls;
  logic            sel_ls;
  logic [SIZE-1:0] addr_q;
  logic [2:0]      ctrl_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            mis_q;
  logic [CW-1:0]   cnt;

  logic            grant_if;
  logic            grant_ls;
  logic            accept;
  logic            ls_mis;
  logic            is_store;
  logic            issue_ok;
  logic [3:0]      we_calc;
  logic [31:0]     wd_calc;

  // Address bits outside the memory window and the ignored IF byte offset.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:SIZE], if_addr[1:0], ls_addr[31:SIZE]};

  // Round-robin on a tie: whoever was not served last wins. last_ls resets
  // to 1 so that IF takes the first tie after reset.
  assign grant_if = if_req_valid && (!ls_req_valid || last_ls);
  assign grant_ls = ls_req_valid && (!if_req_valid || !last_ls);

  assign if_req_ready = rst_n && (state == ST_IDLE) && grant_if;
  assign ls_req_ready = rst_n && (state == ST_IDLE) && grant_ls;
  assign accept       = if_req_ready || ls_req_ready;

  // Halfwords need addr[0]=0 and words need addr[1:0]=0; bytes always fit.
  always_comb begin
    ls_mis = 1'b0;
    case (ls_ctrl)
      3'b001, 3'b100, 3'b110: ls_mis = ls_addr[0];
      3'b010, 3'b111:         ls_mis = |ls_addr[1:0];
      default:                ls_mis = 1'b0;
    endcase
  end

  assign is_store = (ctrl_q == 3'b101) || (ctrl_q == 3'b110) || (ctrl_q == 3'b111);

  // Byte enables and lane-replicated store data for the registered request.
  always_comb begin
    we_calc = 4'b0000;
    wd_calc = 32'h0;
    case (ctrl_q)
      3'b101: begin
        we_calc = 4'b0001 << addr_q[1:0];
        wd_calc = {4{wdata_q[7:0]}};
      end
      3'b110: begin
        we_calc = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_calc = {2{wdata_q[15:0]}};
      end
      3'b111: begin
        we_calc = 4'b1111;
        wd_calc = wdata_q;
      end
      default: begin
        we_calc = 4'b0000;
        wd_calc = 32'h0;
      end
    endcase
  end

  // Sequencer. IF requests are stored as an aligned LW so that the shared
  // store/misalignment decode treats them as plain word reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      last_ls <= 1'b1;
      sel_ls  <= 1'b0;
      addr_q  <= '0;
      ctrl_q  <= 3'b000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_ISSUE;
            sel_ls  <= ls_req_ready;
            last_ls <= ls_req_ready;
            rdata_q <= 32'h0;
            if (ls_req_ready) begin
              addr_q  <= ls_addr[SIZE-1:0];
              ctrl_q  <= ls_ctrl;
              wdata_q <= ls_wdata;
              mis_q   <= ls_mis;
            end else begin
              addr_q  <= {if_addr[SIZE-1:2], 2'b00};
              ctrl_q  <= 3'b010;
              wdata_q <= 32'h0;
              mis_q   <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= CW'(RD_LAT - 1);
          state <= (is_store || mis_q) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rdata_q <= mem_rdata >> {addr_q[1:0], 3'b000};
            state   <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A misaligned access still passes through ISSUE but never strobes memory.
  assign issue_ok  = (state == ST_ISSUE) && !mis_q;
  assign mem_en    = issue_ok;
  assign mem_we    = issue_ok ? we_calc : 4'b0000;
  assign mem_wdata = issue_ok ? wd_calc : 32'h0;
  assign mem_addr  = (state == ST_ISSUE) ? {addr_q[SIZE-1:2], 2'b00} : '0;

  assign if_rsp_valid = (state == ST_RESP) && !sel_ls;
  assign if_rdata     = if_rsp_valid ? rdata_q : 32'h0;
  assign ls_rsp_valid = (state == ST_RESP) && sel_ls;
  assign ls_err       = ls_rsp_valid && mis_q;
  assign ls_rdata     = (ls_rsp_valid && !is_store && !mis_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        if_req_valid = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        ls_req_valid = 1'b0;
  logic        ls3_req_valid = 1'b0;
  logic [31:0] ls_addr = 32'h0;
  logic [2:0]  ls_ctrl = 3'b000;
  logic [31:0] ls_wdata = 32'h0;

  logic        if_req_ready, if_rsp_valid, ls_req_ready, ls_rsp_valid, ls_err, mem_en;
  logic [31:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;

  logic        d3_if_req_ready, d3_if_rsp_valid, d3_ls_req_ready, d3_ls_rsp_valid, d3_ls_err, d3_mem_en;
  logic [31:0] d3_if_rdata, d3_ls_rdata, d3_mem_wdata, d3_mem_rdata;
  logic [3:0]  d3_mem_we;
  logic [11:0] d3_mem_addr;

  logic [31:0] mem_words [0:1023];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.SIZE(12), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_ctrl(ls_ctrl), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.SIZE(12), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(1'b0), .if_req_ready(d3_if_req_ready), .if_addr(32'h0),
    .if_rsp_valid(d3_if_rsp_valid), .if_rdata(d3_if_rdata),
    .ls_req_valid(ls3_req_valid), .ls_req_ready(d3_ls_req_ready), .ls_addr(ls_addr),
    .ls_ctrl(ls_ctrl), .ls_wdata(ls_wdata),
    .ls_rsp_valid(d3_ls_rsp_valid), .ls_rdata(d3_ls_rdata), .ls_err(d3_ls_err),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
    .mem_rdata(d3_mem_rdata)
  );

  // Memory models: data is valid only in the single cycle RD_LAT after
  // mem_en; any other cycle returns a poison pattern.
  logic        p1_vld = 1'b0;
  logic [31:0] p1_data = 32'h0;
  always @(posedge clk) begin
    p1_vld  <= mem_en;
    p1_data <= mem_words[mem_addr[11:2]];
  end
  assign mem_rdata = p1_vld ? p1_data : 32'hBAD0BAD0;

  logic [2:0]  p3_vld = 3'b000;
  logic [31:0] p3_d0 = 32'h0, p3_d1 = 32'h0, p3_d2 = 32'h0;
  always @(posedge clk) begin
    p3_vld <= {p3_vld[1:0], d3_mem_en};
    p3_d0  <= mem_words[d3_mem_addr[11:2]];
    p3_d1  <= p3_d0;
    p3_d2  <= p3_d1;
  end
  assign d3_mem_rdata = p3_vld[2] ? p3_d2 : 32'hBAD0BAD0;

  typedef struct {
    bit          is_ls;
    logic [31:0] addr;
    logic [2:0]  ctrl;
    logic [31:0] wdata;
    logic [31:0] word;
    bit          exp_en;
    logic [3:0]  exp_we;
    logic [11:0] exp_maddr;
    logic [31:0] exp_mwdata;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(bit is_ls, logic [31:0] addr, logic [2:0] ctrl, logic [31:0] wdata,
                              logic [31:0] word, bit en, logic [3:0] we, logic [11:0] maddr,
                              logic [31:0] mwd, int lat, bit err, logic [31:0] rd);
    vec_t v;
    v.is_ls = is_ls; v.addr = addr; v.ctrl = ctrl; v.wdata = wdata; v.word = word;
    v.exp_en = en; v.exp_we = we; v.exp_maddr = maddr; v.exp_mwdata = mwd;
    v.exp_lat = lat; v.exp_err = err; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checkOutput(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    chk1({tag, ".if_ready"}, if_req_ready, 1'b0);
    chk1({tag, ".ls_ready"}, ls_req_ready, 1'b0);
    chk1({tag, ".if_rsp"}, if_rsp_valid, 1'b0);
    chk1({tag, ".ls_rsp"}, ls_rsp_valid, 1'b0);
    chk1({tag, ".ls_err"}, ls_err, 1'b0);
    chk1({tag, ".mem_en"}, mem_en, 1'b0);
    checkOutput({tag, ".if_rdata"}, if_rdata, 32'h0);
    checkOutput({tag, ".ls_rdata"}, ls_rdata, 32'h0);
    checkOutput({tag, ".mem_we"}, {28'h0, mem_we}, 32'h0);
    checkOutput({tag, ".mem_addr"}, {20'h0, mem_addr}, 32'h0);
    checkOutput({tag, ".mem_wdata"}, mem_wdata, 32'h0);
  endtask

  // One complete single-requester transaction on the RD_LAT=1 instance.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   waited;
    logic rdy;
    logic rv;
    mem_words[v.addr[11:2]] = v.word;
    if (v.is_ls) begin
      ls_req_valid = 1'b1; ls_addr = v.addr; ls_ctrl = v.ctrl; ls_wdata = v.wdata;
    end else begin
      if_req_valid = 1'b1; if_addr = v.addr;
    end
    #1;
    waited = 0;
    rdy = v.is_ls ? ls_req_ready : if_req_ready;
    while (!rdy && waited < 10) begin
      step();
      waited++;
      rdy = v.is_ls ? ls_req_ready : if_req_ready;
    end
    chk1({tag, ".ready"}, rdy, 1'b1);
    if (!rdy) begin
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      return;
    end
    step();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    chk1({tag, ".mem_en"}, mem_en, v.exp_en);
    checkOutput({tag, ".mem_we"}, {28'h0, mem_we}, {28'h0, v.exp_we});
    if (v.exp_en) begin
      checkOutput({tag, ".mem_addr"}, {20'h0, mem_addr}, {20'h0, v.exp_maddr});
      checkOutput({tag, ".mem_wdata"}, mem_wdata, v.exp_mwdata);
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      rv = v.is_ls ? ls_rsp_valid : if_rsp_valid;
      chk1($sformatf("%s.rsp_valid@T+%0d", tag, k), rv, k == v.exp_lat);
      if (k == v.exp_lat) begin
        if (v.is_ls) begin
          checkOutput({tag, ".ls_rdata"}, ls_rdata, v.exp_rdata);
          chk1({tag, ".ls_err"}, ls_err, v.exp_err);
        end else begin
          checkOutput({tag, ".if_rdata"}, if_rdata, v.exp_rdata);
        end
      end
    end
  endtask

  initial begin
    int   waited;
    logic any_rdy;

    //            ls  addr          ctrl    wdata         word          en  we       maddr   mwdata        lat err rdata
    vecs[0]  = mk(0, 32'h0000_0105, 3'b000, 32'h0,        32'hDEADBEEF, 1, 4'b0000, 12'h104, 32'h0,        3, 0, 32'hDEADBEEF);
    vecs[1]  = mk(1, 32'h0000_0013, 3'b101, 32'h0000_00A5, 32'h0,       1, 4'b1000, 12'h010, 32'hA5A5A5A5, 2, 0, 32'h0);
    vecs[2]  = mk(1, 32'h0000_0006, 3'b001, 32'h0,        32'h12345678, 1, 4'b0000, 12'h004, 32'h0,        3, 0, 32'h00001234);
    vecs[3]  = mk(1, 32'h0000_0002, 3'b111, 32'h11223344, 32'h0,        0, 4'b0000, 12'h000, 32'h0,        2, 1, 32'h0);
    vecs[4]  = mk(1, 32'h0000_000A, 3'b110, 32'hFFFFBEEF, 32'h0,        1, 4'b1100, 12'h008, 32'hBEEFBEEF, 2, 0, 32'h0);
    vecs[5]  = mk(1, 32'h0000_000C, 3'b010, 32'h0,        32'hCAFEF00D, 1, 4'b0000, 12'h00C, 32'h0,        3, 0, 32'hCAFEF00D);
    vecs[6]  = mk(1, 32'h0000_00FF, 3'b011, 32'h0,        32'h89ABCDEF, 1, 4'b0000, 12'h0FC, 32'h0,        3, 0, 32'h00000089);
    vecs[7]  = mk(1, 32'h0000_0001, 3'b100, 32'h0,        32'h0,        0, 4'b0000, 12'h000, 32'h0,        2, 1, 32'h0);
    vecs[8]  = mk(0, 32'h0000_07FE, 3'b000, 32'h0,        32'h13579BDF, 1, 4'b0000, 12'h7FC, 32'h0,        3, 0, 32'h13579BDF);
    vecs[9]  = mk(1, 32'h0000_0000, 3'b101, 32'h1234567E, 32'h0,        1, 4'b0001, 12'h000, 32'h7E7E7E7E, 2, 0, 32'h0);
    vecs[10] = mk(1, 32'h0000_0002, 3'b000, 32'h0,        32'hAABBCCDD, 1, 4'b0000, 12'h000, 32'h0,        3, 0, 32'h0000AABB);
    vecs[11] = mk(1, 32'h0000_0004, 3'b110, 32'h00001234, 32'h0,        1, 4'b0011, 12'h004, 32'h12341234, 2, 0, 32'h0);
    vecs[12] = mk(1, 32'h0000_0803, 3'b010, 32'h0,        32'h0,        0, 4'b0000, 12'h000, 32'h0,        2, 1, 32'h0);
    vecs[13] = mk(0, 32'hFFFF_F010, 3'b000, 32'h0,        32'h2468ACE0, 1, 4'b0000, 12'h010, 32'h0,        3, 0, 32'h2468ACE0);
    vecs[14] = mk(1, 32'h0000_0002, 3'b001, 32'h0,        32'h87654321, 1, 4'b0000, 12'h000, 32'h0,        3, 0, 32'h00008765);

    // Reset state, then both requesters valid while still in reset.
    repeat (3) step();
    checkAllZero("reset");
    if_req_valid = 1'b1; if_addr = 32'h100;
    ls_req_valid = 1'b1; ls_addr = 32'h200; ls_ctrl = 3'b010; ls_wdata = 32'h0;
    #1;
    chk1("reset.if_ready_valid", if_req_ready, 1'b0);
    chk1("reset.ls_ready_valid", ls_req_ready, 1'b0);
    step();

    // Both valid every cycle from reset: grants alternate IF, LS, IF, LS.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      waited = 0;
      any_rdy = if_req_ready || ls_req_ready;
      while (!any_rdy && waited < 10) begin
        step();
        waited++;
        any_rdy = if_req_ready || ls_req_ready;
      end
      chk1($sformatf("tie%0d.some_ready", n), any_rdy, 1'b1);
      chk1($sformatf("tie%0d.both_ready", n), if_req_ready && ls_req_ready, 1'b0);
      chk1($sformatf("tie%0d.grant_ls", n), ls_req_ready, n[0]);
      step();
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    repeat (5) step();

    // Directed vector table on the RD_LAT=1 instance.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // LH 0x006 on the RD_LAT=3 instance: pulse at T+5.
    mem_words[1] = 32'h12345678;
    ls3_req_valid = 1'b1; ls_addr = 32'h006; ls_ctrl = 3'b001; ls_wdata = 32'h0;
    #1;
    waited = 0;
    while (!d3_ls_req_ready && waited < 10) begin
      step();
      waited++;
    end
    chk1("lat3.ready", d3_ls_req_ready, 1'b1);
    step();
    ls3_req_valid = 1'b0;
    chk1("lat3.mem_en", d3_mem_en, 1'b1);
    for (int k = 2; k <= 7; k++) begin
      step();
      chk1($sformatf("lat3.rsp_valid@T+%0d", k), d3_ls_rsp_valid, k == 5);
      if (k == 5) begin
        checkOutput("lat3.ls_rdata", d3_ls_rdata, 32'h00001234);
        chk1("lat3.ls_err", d3_ls_err, 1'b0);
      end
    end

    // Reset asserted while an IF read is in WAIT: no response pulse.
    mem_words[10'h041] = 32'hDEADBEEF;
    if_req_valid = 1'b1; if_addr = 32'h104;
    #1;
    waited = 0;
    while (!if_req_ready && waited < 10) begin
      step();
      waited++;
    end
    chk1("rstwait.ready", if_req_ready, 1'b1);
    step();
    if_req_valid = 1'b0;
    chk1("rstwait.mem_en", mem_en, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    checkAllZero("rstwait.t3");
    step();
    checkAllZero("rstwait.t4");
    rst_n = 1'b1;
    step();
    applyStimulus(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
